// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake from the fabric side plus the serial line and
// status outputs of uart_tx.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       data_valid_in;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       tx_done;

    // Fabric / line side: supplies bytes, observes the line and status.
    modport master (
        output data_in,
        output data_valid_in,
        input  ready,
        input  tx,
        input  busy,
        input  tx_done
    );

    // Transmitter side.
    modport slave (
        input  data_in,
        input  data_valid_in,
        output ready,
        output tx,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 (by default) serial transmitter with a one-byte holding register
// behind the shift register, so back-to-back frames leave no idle gap.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the data.
module uart_tx #(
    parameter int unsigned CLOCK_FREQ = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input logic      clk,
    input logic      rst,
    uart_tx_if.slave bus
);
    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W = ($clog2(CLKS_PER_BIT) > 16) ? $clog2(CLKS_PER_BIT) : 16;
    localparam logic [CNT_W-1:0] LAST_CLK  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    // Reject configurations the datapath cannot represent.
    if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd4,
`endif
        StStop   = 3'd3
    } state_e;

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_next;
    logic [2:0]       r_bit_idx, w_bit_idx_next;
    logic [7:0]       r_shift, w_shift_next;
    logic [7:0]       r_hold;
    logic             r_hold_full;
    logic             r_tx, w_tx_next;
    logic             r_done_pre, r_tx_done;
    logic             w_load, w_stop_last, w_cnt_wrap, w_accept;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
`endif

    assign w_cnt_wrap = (r_clk_cnt == LAST_CLK);
    assign w_accept   = bus.data_valid_in && !r_hold_full;

    // State, counters and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    // Next-state logic and the value tx takes on the following edge.
    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_load         = 1'b0;
        w_stop_last    = 1'b0;
        w_tx_next      = 1'b1;
        case (r_state)
            StIdle: begin
                w_load = r_hold_full;
            end
            StStart: begin
                w_tx_next = 1'b0;
                if (w_cnt_wrap) begin
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = StData;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            StData: begin
                w_tx_next = r_shift[0];
                if (w_cnt_wrap) begin
                    w_clk_cnt_next = '0;
                    w_shift_next   = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next   = StParity;
`else
                        w_state_next   = StStop;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                w_tx_next = r_parity;
                if (w_cnt_wrap) begin
                    w_clk_cnt_next = '0;
                    w_state_next   = StStop;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
`endif
            StStop: begin
                if (w_cnt_wrap) begin
                    w_clk_cnt_next = '0;
                    if (r_bit_idx == LAST_STOP) begin
                        w_stop_last  = 1'b1;
                        w_state_next = StIdle;
                        // A waiting byte chains straight into the next start bit.
                        w_load       = r_hold_full;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        if (w_load) begin
            w_shift_next   = r_hold;
            w_clk_cnt_next = '0;
            w_bit_idx_next = '0;
            w_state_next   = StStart;
        end
    end

    // Holding register; ready is low on the load cycle, so accept and load never overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= bus.data_in;
            r_hold_full <= 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured with the byte so it is stable for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= (^r_hold) ^ PARITY_ODD[0];
        end
    end
`endif

    // Registered line and done pulse; done is delayed one extra cycle so it
    // coincides with the end of the last stop bit as seen on the registered tx.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx       <= 1'b1;
            r_done_pre <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx       <= w_tx_next;
            r_done_pre <= w_stop_last;
            r_tx_done  <= r_done_pre;
        end
    end

    assign bus.ready   = !r_hold_full;
    assign bus.busy    = (r_state != StIdle) || r_hold_full;
    assign bus.tx      = r_tx;
    assign bus.tx_done = r_tx_done;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. DUT0 uses one stop bit and even
// parity, DUT1 two stop bits and odd parity (parity only with UART_TX_PARITY_EN).
module tb_uart_tx;
    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL0 = (10 + PAR) * CPB;
    localparam int FL1 = (11 + PAR) * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int         checks   = 0;
    int         errors   = 0;
    int         spurious = 0;
    logic [7:0] exp_q[$];
    int         start_e[$];
    int         done_e[$];

    uart_tx_if bus0();
    uart_tx_if bus1();

    uart_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(1), .PARITY_ODD(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );
    uart_tx #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(2), .PARITY_ODD(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic [7:0] data_r [2];
    logic       valid_r [2];
    logic       tx_w [2];
    logic       done_w [2];
    logic       ready_w [2];
    logic       busy_w [2];

    assign bus0.data_in       = data_r[0];
    assign bus0.data_valid_in = valid_r[0];
    assign bus1.data_in       = data_r[1];
    assign bus1.data_valid_in = valid_r[1];
    assign tx_w[0]    = bus0.tx;
    assign tx_w[1]    = bus1.tx;
    assign done_w[0]  = bus0.tx_done;
    assign done_w[1]  = bus1.tx_done;
    assign ready_w[0] = bus0.ready;
    assign ready_w[1] = bus1.ready;
    assign busy_w[0]  = bus0.busy;
    assign busy_w[1]  = bus1.busy;

    // Expected line level per bit slot: start, 8 data LSB first, [parity], stops.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input int g);
        logic [11:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        if (PAR == 1) b[9] = (^d) ^ logic'(g == 1);
        return b;
    endfunction

    // Line monitor: pops the expected byte at each start bit, checks every
    // cycle of the frame and the tx_done pulse right after it.
    task automatic monitor();
        int          pos [2];
        int          bad [2];
        int          first_bad [2];
        bit          in_f [2];
        bit          pend [2];
        logic [11:0] bits [2];
        logic [7:0]  cur [2];
        int          fl;
        for (int g = 0; g < 2; g++) begin
            in_f[g] = 1'b0;
            pend[g] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                fl = (g == 0) ? FL0 : FL1;
                if (rst === 1'b1) begin
                    in_f[g] = 1'b0;
                    pend[g] = 1'b0;
                end else begin
                    if (pend[g]) begin
                        checks++;
                        if (done_w[g] !== 1'b1) begin
                            errors++;
                            $display("FAIL tx_done_end_of_frame dut%0d: tx_done=%b, required 1",
                                     g, done_w[g]);
                        end
                        done_e.push_back(edge_cnt);
                        pend[g] = 1'b0;
                    end else if (done_w[g] === 1'b1) begin
                        spurious++;
                    end
                    if (in_f[g]) begin
                        if (tx_w[g] !== bits[g][pos[g] / CPB]) begin
                            if (bad[g] == 0) first_bad[g] = pos[g];
                            bad[g]++;
                        end
                        pos[g]++;
                        if (pos[g] == fl) begin
                            in_f[g] = 1'b0;
                            pend[g] = 1'b1;
                            checks++;
                            if (bad[g] != 0) begin
                                errors++;
                                $display("FAIL frame_dut%0d byte %h: %0d wrong tx cycles (first at %0d), required 0",
                                         g, cur[g], bad[g], first_bad[g]);
                            end
                        end
                    end else if (tx_w[g] === 1'b0) begin
                        start_e.push_back(edge_cnt);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame dut%0d: start bit seen, required no frame", g);
                            cur[g] = 8'h00;
                        end else begin
                            cur[g] = exp_q.pop_front();
                        end
                        bits[g]      = frame_bits(cur[g], g);
                        pos[g]       = 1;
                        bad[g]       = 0;
                        first_bad[g] = 0;
                        in_f[g]      = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic send(input int g, input logic [7:0] d, output int acc);
        int n;
        n   = 0;
        acc = -1;
        @(negedge clk);
        while (ready_w[g] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready_w[g] !== 1'b1) begin
            errors++;
            $display("FAIL send_wait_ready dut%0d: ready=%b after %0d cycles, required 1",
                     g, ready_w[g], n);
            return;
        end
        data_r[g]  = d;
        valid_r[g] = 1'b1;
        @(posedge clk);
        #1;
        acc        = edge_cnt;
        exp_q.push_back(d);
        valid_r[g] = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_w[g] !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop dut%0d: ready=%b, required 0", g, ready_w[g]);
        end
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (done_e.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done_e.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: %0d frames done, required %0d", name, done_e.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks += 4;
            if (tx_w[g] !== 1'b1) begin
                errors++; $display("FAIL reset_tx dut%0d: %b, required 1", g, tx_w[g]);
            end
            if (ready_w[g] !== 1'b1) begin
                errors++; $display("FAIL reset_ready dut%0d: %b, required 1", g, ready_w[g]);
            end
            if (busy_w[g] !== 1'b0) begin
                errors++; $display("FAIL reset_busy dut%0d: %b, required 0", g, busy_w[g]);
            end
            if (done_w[g] !== 1'b0) begin
                errors++; $display("FAIL reset_tx_done dut%0d: %b, required 0", g, done_w[g]);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        int acc, ns, nd, lat;
        ns = start_e.size();
        nd = done_e.size();
        send(0, 8'hA5, acc);
        wait_done(nd + 1, 400, "single");
        lat = (start_e.size() > ns) ? start_e[ns] - acc : -1;
        checks++;
        if (lat != 2) begin
            errors++; $display("FAIL single_start_latency: %0d edges, required 2", lat);
        end
        @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b0) begin
            errors++; $display("FAIL single_busy_after: %b, required 0", busy_w[0]);
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2, ns, nd, gap;
        ns = start_e.size();
        nd = done_e.size();
        send(0, 8'h00, a1);
        send(0, 8'hFF, a2);
        wait_done(nd + 2, 600, "back_to_back");
        gap = (start_e.size() >= ns + 2) ? start_e[ns + 1] - start_e[ns] : -1;
        checks++;
        if (gap != FL0) begin
            errors++; $display("FAIL back_to_back_start_spacing: %0d, required %0d", gap, FL0);
        end
    endtask

    task automatic test_backpressure();
        int a, nd, n;
        bit accepted;
        nd       = done_e.size();
        accepted = 1'b0;
        n        = 0;
        send(0, 8'h11, a);
        send(0, 8'h22, a);
        valid_r[0] = 1'b1;
        data_r[0]  = 8'($urandom);
        while (n < 300) begin
            @(negedge clk);
            if (ready_w[0] === 1'b1) begin
                exp_q.push_back(data_r[0]);
                @(posedge clk);
                #1 valid_r[0] = 1'b0;
                accepted = 1'b1;
                break;
            end
            data_r[0] = 8'($urandom);
            n++;
        end
        valid_r[0] = 1'b0;
        checks++;
        if (!accepted || n < 90) begin
            errors++;
            $display("FAIL backpressure_ready_low: accepted=%0d after %0d cycles, required 1 after >=90",
                     accepted, n);
        end
        wait_done(nd + 3, 800, "backpressure");
    endtask

    task automatic test_reset_mid();
        int a, ns, nd, n, s, spur0;
        ns = start_e.size();
        nd = done_e.size();
        n  = 0;
        send(0, 8'h3C, a);
        send(0, 8'h5A, a);
        while (start_e.size() <= ns && n < 100) begin
            @(negedge clk);
            n++;
        end
        s = (start_e.size() > ns) ? start_e[ns] : edge_cnt;
        while (edge_cnt < s + 44 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (tx_w[0] !== 1'b1) begin
            errors++; $display("FAIL reset_mid_tx: %b, required 1", tx_w[0]);
        end
        if (ready_w[0] !== 1'b1) begin
            errors++; $display("FAIL reset_mid_ready: %b, required 1", ready_w[0]);
        end
        if (busy_w[0] !== 1'b0) begin
            errors++; $display("FAIL reset_mid_busy: %b, required 0", busy_w[0]);
        end
        if (done_w[0] !== 1'b0) begin
            errors++; $display("FAIL reset_mid_tx_done: %b, required 0", done_w[0]);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        spur0 = spurious;
        repeat (250) @(negedge clk);
        checks += 3;
        if (start_e.size() != ns + 1) begin
            errors++;
            $display("FAIL reset_mid_frames: %0d starts, required %0d", start_e.size(), ns + 1);
        end
        if (done_e.size() != nd || spurious != spur0) begin
            errors++;
            $display("FAIL reset_mid_no_done: %0d done/%0d stray pulses, required %0d/%0d",
                     done_e.size(), spurious, nd, spur0);
        end
        if (tx_w[0] !== 1'b1) begin
            errors++; $display("FAIL reset_mid_idle_line: %b, required 1", tx_w[0]);
        end
    endtask

    task automatic test_two_stop();
        int acc, ns, nd, lat;
        ns = start_e.size();
        nd = done_e.size();
        send(1, 8'h55, acc);
        wait_done(nd + 1, 400, "two_stop");
        lat = (start_e.size() > ns) ? start_e[ns] - acc : -1;
        checks++;
        if (lat != 2) begin
            errors++; $display("FAIL two_stop_start_latency: %0d edges, required 2", lat);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int acc, nd;
        nd = done_e.size();
        send(0, 8'hA5, acc);
        wait_done(nd + 1, 400, "parity_even");
        send(1, 8'hA5, acc);
        wait_done(nd + 2, 400, "parity_odd");
    endtask
`endif

    task automatic test_quiet();
        repeat (20) @(negedge clk);
        checks += 3;
        if (spurious != 0) begin
            errors++; $display("FAIL stray_tx_done: %0d pulses, required 0", spurious);
        end
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL bytes_not_sent: %0d left, required 0", exp_q.size());
        end
        if (busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0) begin
            errors++; $display("FAIL final_busy: %b%b, required 00", busy_w[0], busy_w[1]);
        end
    endtask

    initial begin
        data_r[0]  = 8'h00;
        data_r[1]  = 8'h00;
        valid_r[0] = 1'b0;
        valid_r[1] = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_two_stop();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_quiet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, 8N1 by default. Counterpart of the team's UART receiver.
- Accepts bytes from on-chip logic over a valid/ready handshake and buffers one byte in a holding register behind the shift register, so consecutive frames go out with no idle gap.
- Drives the serial `tx` line. Sits between the system/fabric side and the pad.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate. CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE, integer division. Must be >= 2.
- STOP_BITS, 1, number of stop bits. Legal values are 1 or 2.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit; sampled on an accepting edge.
- data_valid_in  input  1  data_in is valid.
- ready  output  1  holding register is empty; a byte can be accepted.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  a frame is in progress or the holding register is full.
- tx_done  output  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high.
- Reset values:
  - tx = 1, ready = 1, busy = 0, tx_done = 0.
  - state = IDLE; bit counter, cycle counter and holding register cleared.
- Handshake:
  - A transfer occurs on a rising edge where data_valid_in && ready. data_in is copied into the holding register and hold_full is set.
  - ready = !hold_full.
  - data_valid_in while ready = 0 is ignored. No stall flag and no overwrite of the held byte.
- State machine: IDLE, START, DATA, PARITY (only if the macro is defined), STOP.
- IDLE:
  - tx = 1.
  - If hold_full: move the byte to the shift register, clear hold_full, clear the counters, go to START.
- Latency: tx goes low exactly 2 clock edges after the accepting edge when the block was idle.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - 8 bits, LSB first, each held for exactly CLKS_PER_BIT cycles.
  - After bit 7, go to PARITY if enabled, otherwise STOP.
- STOP:
  - tx = 1 for STOP_BITS * CLKS_PER_BIT cycles.
  - On the final cycle of STOP, tx_done is asserted for the following cycle.
  - If hold_full at that edge: load the held byte and go directly to START, giving zero idle cycles between frames.
  - Otherwise return to IDLE.
- Frame length: (10 + STOP_BITS - 1 + parity) * CLKS_PER_BIT cycles, with parity = 1 if enabled, else 0.
- Holding register:
  - Can be refilled on any cycle after it empties, including mid-frame.
  - The load from holding into the shift register and a new accept cannot coincide, because ready = 0 during the load cycle.
- busy = (state != IDLE) || hold_full.
- Reset mid-frame:
  - tx returns to 1 on the reset edge and the held byte is discarded.
  - No tx_done pulse is produced for the aborted frame.
- Cycle counter: at least 16 bits; wraps to 0 at CLKS_PER_BIT - 1 and never overflows.
- Unused states decode to IDLE with tx = 1.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - The PARITY state follows DATA for CLKS_PER_BIT cycles.
  - tx = XOR of the 8 data bits, XORed with PARITY_ODD.
  - Frame length grows by CLKS_PER_BIT.
- When undefined:
  - No PARITY state, no parity logic; PARITY_ODD is ignored.
  - Frame is start + 8 data + stop bits.

Test Plan (CLOCK_FREQ=1000, BAUD_RATE=100, so CLKS_PER_BIT=10; STOP_BITS=1 unless stated):
- Single byte:
  - Stimulus: reset, then send 0xA5 with one valid pulse while idle.
  - Required response: ready drops the next cycle; tx low exactly 2 edges after accept for 10 cycles; then data bits 1,0,1,0,0,1,0,1 at 10 cycles each; then high for 10 cycles; tx_done pulses once 100 cycles after tx fell; busy is 0 afterwards.
- Back-to-back:
  - Stimulus: send 0x00, then 0xFF as soon as ready rises.
  - Required response: second start bit begins on the cycle immediately after the first frame's stop bit ends (0 idle cycles); two tx_done pulses exactly 100 cycles apart.
- Backpressure:
  - Stimulus: hold data_valid_in = 1 with changing data_in while ready = 0.
  - Required response: only the bytes sampled when ready = 1 are transmitted; the held byte is never corrupted.
- Reset mid-frame:
  - Stimulus: assert rst during data bit 3 of 0x3C, with a second byte held.
  - Required response: tx = 1 on the next edge; ready = 1; busy = 0; no tx_done; no further frame is sent.
- Two stop bits:
  - Stimulus: STOP_BITS=2, send 0x55.
  - Required response: stop high for 20 cycles; tx_done 110 cycles after the start edge.
- Parity (UART_TX_PARITY_EN defined):
  - Stimulus: send 0xA5 with PARITY_ODD=0, then with PARITY_ODD=1.
  - Required response: parity bit is 0 and 1 respectively; frame length is 110 cycles.
